// File: rtl/mult4_rr_arbiter.sv
// Round-robin arbiter sharing one 4x4 unsigned shift-add array multiplier between NREQ requesters.
// Each result is registered and tagged with the index of the requester that supplied the operands.
module mult4_rr_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [4*NREQ-1:0]    req_a,
    input  logic [4*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [7:0]           resp_y,
    output logic [IDW-1:0]       resp_id,
    output logic                 busy
);

    localparam int unsigned OPW = 4;
    localparam int unsigned PW  = 2 * OPW;
    localparam int unsigned SW  = IDW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   rr_ptr;
    logic [OPW-1:0]   op_a;
    logic [OPW-1:0]   op_b;
    logic [IDW-1:0]   op_id;

    logic             window_open;
    logic             grant_hit;
    logic             grant;
    logic [IDW-1:0]   grant_id;
    logic [OPW-1:0]   grant_a;
    logic [OPW-1:0]   grant_b;
    logic [PW-1:0]    mul_y;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Round-robin search starting at rr_ptr, wrapping modulo NREQ
    always_comb begin
        logic [SW-1:0]  sum;
        logic [IDW-1:0] cand;
        sum       = '0;
        cand      = '0;
        grant_hit = 1'b0;
        grant_id  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + SW'(k);
            if (sum >= SW'(NREQ)) begin
                sum = sum - SW'(NREQ);
            end
            cand = sum[IDW-1:0];
            if (!grant_hit && req_valid[cand]) begin
                grant_hit = 1'b1;
                grant_id  = cand;
            end
        end
    end

    // Grant only in IDLE or when the held result is being consumed
    always_comb begin
        window_open = !rst && ((state == IDLE) || ((state == DONE) && resp_ready));
        grant       = window_open && grant_hit;
        grant_a     = '0;
        grant_b     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant_id) begin
                grant_a = req_a[OPW*i +: OPW];
                grant_b = req_b[OPW*i +: OPW];
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                state_nxt = DONE;
            end
            DONE: begin
                if (resp_ready) begin
                    state_nxt = grant ? CALC : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        req_ready  = '0;
        resp_valid = (state == DONE);
        busy       = (state == CALC) || (state == DONE);
        if (grant) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // multiplier_4: shift-add array of partial products
    always_comb begin
        mul_y = '0;
        for (int unsigned i = 0; i < OPW; i++) begin
            if (op_b[i]) begin
                mul_y = mul_y + (PW'(op_a) << i);
            end
        end
    end

    // Operand, pointer and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            op_a    <= '0;
            op_b    <= '0;
            op_id   <= '0;
            resp_y  <= '0;
            resp_id <= '0;
        end else begin
            if (grant) begin
                op_a   <= grant_a;
                op_b   <= grant_b;
                op_id  <= grant_id;
                rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
            end
            if (state == CALC) begin
                resp_y  <= mul_y;
                resp_id <= op_id;
            end
        end
    end

endmodule

// File: tb/tb_mult4_rr_arbiter.sv
// Directed bench for mult4_rr_arbiter: reset, round-robin order, product values,
// back-pressure hold, pointer wrap and reset during a calculation.
module tb_mult4_rr_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [4*NREQ-1:0] req_a;
    logic [4*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [7:0]        resp_y;
    logic [IDW-1:0]    resp_id;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mult4_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_edge();
        rst        = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b0;
        drive_edge();
        rst = 1'b0;
    endtask

    task automatic set_req(input int idx, input logic [3:0] a, input logic [3:0] b);
        req_valid[idx]   = 1'b1;
        req_a[4*idx +: 4] = a;
        req_b[4*idx +: 4] = b;
    endtask

    // One full transaction from a single requester with resp_ready held high
    task automatic do_mul(input int idx, input logic [3:0] a, input logic [3:0] b,
                          output logic [7:0] y, output logic [1:0] id);
        bit seen;
        y  = '0;
        id = '0;
        resp_ready = 1'b1;
        set_req(idx, a, b);
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (req_ready[idx]) seen = 1'b1;
            else drive_edge();
        end
        if (!seen) check("grant_timeout", 32'(req_ready), 32'(4'b1 << idx));
        drive_edge();
        req_valid[idx] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            @(negedge clk);
            if (resp_valid) seen = 1'b1;
            else drive_edge();
        end
        if (!seen) check("resp_timeout", 32'(resp_valid), 32'd1);
        y  = resp_y;
        id = resp_id;
        drive_edge();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] y;
        logic [1:0] id;
        logic [7:0] prod_tab [4];
        logic [3:0] oh;

        rst        = 1'b1;
        req_valid  = 4'hF;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        drive_edge();
        drive_edge();

        // Reset state, req_ready suppressed while rst is high
        @(negedge clk);
        check("rst_ready",  32'(req_ready),  32'd0);
        check("rst_valid",  32'(resp_valid), 32'd0);
        check("rst_y",      32'(resp_y),     32'd0);
        check("rst_id",     32'(resp_id),    32'd0);
        check("rst_busy",   32'(busy),       32'd0);
        check("rst_ptr",    32'(dut.rr_ptr), 32'd0);

        // Single request 3*5 from requester 0
        drive_edge();
        rst        = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        set_req(0, 4'd3, 4'd5);
        @(negedge clk);
        check("t1_ready",   32'(req_ready), 32'b0001);
        drive_edge();
        req_valid = '0;
        @(negedge clk);
        check("t1_calc_ready", 32'(req_ready),  32'd0);
        check("t1_calc_valid", 32'(resp_valid), 32'd0);
        check("t1_calc_busy",  32'(busy),       32'd1);
        drive_edge();
        @(negedge clk);
        check("t1_valid", 32'(resp_valid), 32'd1);
        check("t1_y",     32'(resp_y),     32'd15);
        check("t1_id",    32'(resp_id),    32'd0);
        drive_edge();
        @(negedge clk);
        check("t1_after_valid", 32'(resp_valid), 32'd0);
        check("t1_after_busy",  32'(busy),       32'd0);
        check("t1_ptr",         32'(dut.rr_ptr), 32'd1);

        // All requesters valid, back-to-back round robin
        do_reset();
        resp_ready = 1'b1;
        prod_tab[0] = 8'd2;
        prod_tab[1] = 8'd6;
        prod_tab[2] = 8'd12;
        prod_tab[3] = 8'd20;
        set_req(0, 4'd1, 4'd2);
        set_req(1, 4'd2, 4'd3);
        set_req(2, 4'd3, 4'd4);
        set_req(3, 4'd4, 4'd5);
        @(negedge clk);
        check("t2_first_ready", 32'(req_ready), 32'b0001);
        for (int r = 0; r < 6; r++) begin
            drive_edge();
            @(negedge clk);
            check($sformatf("t2_calc_valid%0d", r), 32'(resp_valid), 32'd0);
            drive_edge();
            @(negedge clk);
            oh = 4'(1 << ((r + 1) % 4));
            check($sformatf("t2_valid%0d", r), 32'(resp_valid), 32'd1);
            check($sformatf("t2_id%0d", r),    32'(resp_id),    32'(r % 4));
            check($sformatf("t2_y%0d", r),     32'(resp_y),     32'(prod_tab[r % 4]));
            check($sformatf("t2_ready%0d", r), 32'(req_ready),  32'(oh));
        end

        // Corner products and exhaustive sweep
        do_reset();
        req_valid = '0;
        do_mul(0, 4'd15, 4'd15, y, id);
        check("t3_15x15", 32'(y), 32'd225);
        do_mul(1, 4'd0, 4'd9, y, id);
        check("t3_0x9", 32'(y), 32'd0);
        do_mul(2, 4'd8, 4'd2, y, id);
        check("t3_8x2", 32'(y), 32'd16);
        check("t3_8x2_id", 32'(id), 32'd2);
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                do_mul(a % 4, 4'(a), 4'(b), y, id);
                check($sformatf("t3_sweep_%0dx%0d", a, b), 32'(y), 32'(a * b));
                check($sformatf("t3_sweep_id_%0dx%0d", a, b), 32'(id), 32'(a % 4));
            end
        end

        // Back-pressure hold in DONE, same-cycle grant on resp_ready rise
        do_reset();
        resp_ready = 1'b0;
        set_req(0, 4'd2, 4'd3);
        @(negedge clk);
        check("t4_ready0", 32'(req_ready), 32'b0001);
        drive_edge();
        req_valid = '0;
        set_req(1, 4'd7, 4'd6);
        @(negedge clk);
        check("t4_calc_ready", 32'(req_ready), 32'd0);
        drive_edge();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t4_hold_valid%0d", c), 32'(resp_valid), 32'd1);
            check($sformatf("t4_hold_y%0d", c),     32'(resp_y),     32'd6);
            check($sformatf("t4_hold_id%0d", c),    32'(resp_id),    32'd0);
            check($sformatf("t4_hold_ready%0d", c), 32'(req_ready),  32'd0);
            drive_edge();
        end
        resp_ready = 1'b1;
        @(negedge clk);
        check("t4_regrant", 32'(req_ready), 32'b0010);
        drive_edge();
        req_valid = '0;
        @(negedge clk);
        check("t4_gap_valid", 32'(resp_valid), 32'd0);
        drive_edge();
        @(negedge clk);
        check("t4_y",  32'(resp_y),  32'd42);
        check("t4_id", 32'(resp_id), 32'd1);
        drive_edge();

        // Pointer wrap after id 3, then search from 0 reaches 2
        do_reset();
        do_mul(3, 4'd3, 4'd3, y, id);
        check("t5_id3",   32'(id),          32'd3);
        check("t5_ptr0",  32'(dut.rr_ptr),  32'd0);
        do_mul(2, 4'd5, 4'd3, y, id);
        check("t5_id2",   32'(id),          32'd2);
        check("t5_y",     32'(y),           32'd15);
        check("t5_ptr3",  32'(dut.rr_ptr),  32'd3);
        set_req(0, 4'd1, 4'd1);
        set_req(2, 4'd1, 4'd1);
        @(negedge clk);
        check("t5_wrap_pick", 32'(req_ready), 32'b0001);
        drive_edge();
        req_valid = '0;

        // Reset while in CALC discards the result
        do_reset();
        resp_ready = 1'b1;
        set_req(1, 4'd5, 4'd5);
        @(negedge clk);
        check("t6_ready", 32'(req_ready), 32'b0010);
        drive_edge();
        req_valid = '0;
        rst       = 1'b1;
        @(negedge clk);
        check("t6_busy_calc", 32'(busy), 32'd1);
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        check("t6_busy",  32'(busy),        32'd0);
        check("t6_valid", 32'(resp_valid),  32'd0);
        check("t6_ptr",   32'(dut.rr_ptr),  32'd0);
        check("t6_y",     32'(resp_y),      32'd0);
        for (int c = 0; c < 3; c++) begin
            drive_edge();
            @(negedge clk);
            check($sformatf("t6_no_stale%0d", c), 32'(resp_valid), 32'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
